// File: rtl/vend_sequencer.sv
// Vending sequencer: coin credit, purchase, dispense handshake and change payout in one registered FSM.
// Optional idle auto-refund in CREDIT is built only when VEND_TIMEOUT_EN is defined.
module vend_sequencer #(
    parameter int PRICE       = 25,
    parameter int CHANGE_UNIT = 5,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coin_in,
    input  logic       buy,
    input  logic       cancel,
    input  logic       drink_fin,
    output logic       drink_contral,
    output logic       money_out_contral,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam int         PCW     = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [7:0] PRICE_V = 8'(PRICE);
    localparam logic [7:0] UNIT_V  = 8'(CHANGE_UNIT);

    state_t         state_q;
    logic [7:0]     credit_q;
    logic           drink_q;
    logic           money_q;
    logic           reject_q;
    logic           pay_low_q;
    logic [PCW-1:0] pulse_cnt_q;

    logic [7:0] coin_val;
    logic [8:0] coin_sum;
    logic       coin_acc;
    logic       reject_now;
    logic [7:0] credit_plus;
    logic       afford;
    logic       pulse_last;
    logic       timeout_hit;

    // Only a single set bit is a coin; anything else decodes to value 0.
    always_comb begin
        coin_val = 8'd0;
        case (coin_in)
            4'b0001: coin_val = 8'd5;
            4'b0010: coin_val = 8'd10;
            4'b0100: coin_val = 8'd20;
            4'b1000: coin_val = 8'd50;
            default: coin_val = 8'd0;
        endcase
    end

    assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_acc    = (coin_val != 8'd0) && !coin_sum[8]
                         && ((state_q == IDLE) || (state_q == CREDIT));
    assign reject_now  = (coin_in != 4'd0) && !coin_acc;
    assign credit_plus = coin_acc ? coin_sum[7:0] : credit_q;
    assign afford      = (credit_q >= PRICE_V);
    assign pulse_last  = (pulse_cnt_q == PCW'(PULSE_CYC - 1));

`ifdef VEND_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TW-1:0] idle_cnt_q;
    logic          activity;

    assign activity    = (coin_in != 4'd0) || buy || cancel;
    assign timeout_hit = (state_q == CREDIT) && !activity
                         && (idle_cnt_q == TW'(TIMEOUT_CYC - 1));

    // Counts quiet cycles in CREDIT only; any activity or leaving CREDIT restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q <= '0;
        end else if ((state_q != CREDIT) || activity || timeout_hit) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // Dispense handshake: drink_contral is a level request held from the purchase edge
    // until drink_fin is sampled high; drink_fin is ignored outside VEND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            credit_q    <= 8'd0;
            drink_q     <= 1'b0;
            money_q     <= 1'b0;
            reject_q    <= 1'b0;
            pay_low_q   <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            reject_q <= reject_now;
            case (state_q)
                IDLE: begin
                    if (coin_acc) begin
                        credit_q <= coin_sum[7:0];
                        state_q  <= CREDIT;
                    end
                end
                CREDIT: begin
                    // Affordability uses the pre-coin credit; a same-cycle coin still lands.
                    if (buy && afford) begin
                        state_q  <= VEND;
                        credit_q <= credit_plus - PRICE_V;
                        drink_q  <= 1'b1;
                    end else if (cancel || timeout_hit) begin
                        state_q     <= CHANGE;
                        credit_q    <= credit_plus;
                        money_q     <= 1'b1;
                        pay_low_q   <= 1'b0;
                        pulse_cnt_q <= '0;
                    end else begin
                        credit_q <= credit_plus;
                    end
                end
                VEND: begin
                    if (drink_fin) begin
                        drink_q <= 1'b0;
                        if (credit_q != 8'd0) begin
                            state_q     <= CHANGE;
                            money_q     <= 1'b1;
                            pay_low_q   <= 1'b0;
                            pulse_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                CHANGE: begin
                    if (!pay_low_q) begin
                        if (pulse_last) begin
                            money_q     <= 1'b0;
                            credit_q    <= credit_q - UNIT_V;
                            pay_low_q   <= 1'b1;
                            pulse_cnt_q <= '0;
                        end else begin
                            pulse_cnt_q <= pulse_cnt_q + 1'b1;
                        end
                    end else if (pulse_last) begin
                        pulse_cnt_q <= '0;
                        pay_low_q   <= 1'b0;
                        if (credit_q == 8'd0) begin
                            state_q <= IDLE;
                        end else begin
                            money_q <= 1'b1;
                        end
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state             = state_q;
    assign credit            = credit_q;
    assign drink_contral     = drink_q;
    assign money_out_contral = money_q;
    assign coin_reject       = reject_q;
    assign busy              = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus randomized coin/purchase sessions
// checked against a transaction-level credit model.
module tb_vend_sequencer;

  localparam int PRICE = 25;
  localparam int CU    = 5;
  localparam int PULSE = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] coin_in = 4'd0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       drink_fin = 1'b0;
  logic       drink_contral;
  logic       money_out_contral;
  logic [7:0] credit;
  logic       coin_reject;
  logic       busy;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  vend_sequencer #(
    .PRICE(PRICE), .CHANGE_UNIT(CU), .PULSE_CYC(PULSE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .buy(buy), .cancel(cancel),
    .drink_fin(drink_fin), .drink_contral(drink_contral),
    .money_out_contral(money_out_contral), .credit(credit),
    .coin_reject(coin_reject), .busy(busy), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // driver tasks: called at a negedge, return at the next negedge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic b, input logic x, input logic f);
    coin_in = c; buy = b; cancel = x; drink_fin = f;
    @(negedge clk);
    coin_in = 4'd0; buy = 1'b0; cancel = 1'b0; drink_fin = 1'b0;
  endtask

  function automatic int coin_value(input logic [3:0] c);
    int tbl[4] = '{5, 10, 20, 50};
    if ($countones(c) != 1) return 0;
    for (int i = 0; i < 4; i++) if (c[i]) return tbl[i];
    return 0;
  endfunction

  task automatic queue_refund(input int from);
    for (int v = from - CU; v >= 0; v -= CU) exp_q.push_back(8'(v));
  endtask

  // scoreboard: watch the payout train, popping the expected credit after each pulse
  task automatic expect_payout(input string tag);
    int guard = 0;
    int hi;
    int lo;
    logic [7:0] want;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s_busy: got %b want 1", tag, busy);
    end
    while (state === 2'd3 && guard < 2000) begin
      hi = 0;
      while (money_out_contral === 1'b1 && guard < 2000) begin hi++; guard++; step(); end
      n_tests++;
      if (hi != PULSE) begin n_fail++; $display("FAIL %s_high_len: got %0d want %0d", tag, hi, PULSE); end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s_extra_pulse: got credit %0d want no more pulses", tag, credit);
      end else begin
        want = exp_q.pop_front();
        if (credit !== want) begin n_fail++; $display("FAIL %s_credit_step: got %0d want %0d", tag, credit, want); end
      end
      lo = 0;
      while (money_out_contral === 1'b0 && state === 2'd3 && guard < 2000) begin lo++; guard++; step(); end
      n_tests++;
      if (lo != PULSE) begin n_fail++; $display("FAIL %s_low_len: got %0d want %0d", tag, lo, PULSE); end
    end
    n_tests++;
    if (guard >= 2000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_payout_done: got %0d pulses left want 0", tag, exp_q.size());
    end
    exp_q.delete();
    n_tests++;
    if ({state, credit, drink_contral, money_out_contral, busy} !== 13'd0) begin
      n_fail++; $display("FAIL %s_end_idle: got state %0d credit %0d want 0/0", tag, state, credit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    n_tests++;
    if ({state, credit, drink_contral, money_out_contral, coin_reject, busy} !== 14'd0) begin
      n_fail++; $display("FAIL reset_state: got state %0d credit %0d want 0", state, credit);
    end
  endtask

  task automatic test_vend_change();
    int held = 0;
    drive(4'b0100, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd20 || state !== 2'd1) begin n_fail++; $display("FAIL vend_coin20: got %0d/%0d want 20/1", credit, state); end
    drive(4'b0010, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd30) begin n_fail++; $display("FAIL vend_coin10: got %0d want 30", credit); end
    drive(4'b0000, 1, 0, 0);
    n_tests++;
    if (state !== 2'd2 || credit !== 8'd5 || drink_contral !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL vend_buy: got state %0d credit %0d drink %b want 2/5/1", state, credit, drink_contral);
    end
    for (int i = 0; i < 4; i++) begin step(); if (drink_contral === 1'b1 && state === 2'd2) held++; end
    n_tests++;
    if (held != 4) begin n_fail++; $display("FAIL vend_drink_hold: got %0d want 4", held); end
    drive(4'b0000, 0, 0, 1);
    n_tests++;
    if (drink_contral !== 1'b0 || state !== 2'd3 || money_out_contral !== 1'b1) begin
      n_fail++; $display("FAIL vend_fin: got drink %b state %0d want 0/3", drink_contral, state);
    end
    queue_refund(5);
    expect_payout("vend");
  endtask

  task automatic test_buy_short_cancel();
    drive(4'b0100, 0, 0, 0);
    drive(4'b0000, 1, 0, 0);
    n_tests++;
    if (state !== 2'd1 || credit !== 8'd20 || drink_contral !== 1'b0) begin
      n_fail++; $display("FAIL short_buy: got state %0d credit %0d want 1/20", state, credit);
    end
    drive(4'b0000, 0, 1, 0);
    n_tests++;
    if (state !== 2'd3) begin n_fail++; $display("FAIL short_cancel: got state %0d want 3", state); end
    queue_refund(20);
    expect_payout("cancel20");
  endtask

  task automatic test_reject();
    drive(4'b0011, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd0 || state !== 2'd0) begin
      n_fail++; $display("FAIL rej_multi: got rej %b credit %0d want 1/0", coin_reject, credit);
    end
    step();
    n_tests++;
    if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL rej_one_cycle: got %b want 0", coin_reject); end
    drive(4'b0100, 0, 0, 0);
    drive(4'b0010, 0, 0, 0);
    drive(4'b0000, 1, 0, 0);
    drive(4'b0001, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd5 || state !== 2'd2) begin
      n_fail++; $display("FAIL rej_in_vend: got rej %b credit %0d state %0d want 1/5/2", coin_reject, credit, state);
    end
    drive(4'b0000, 0, 0, 1);
    queue_refund(5);
    expect_payout("rej_vend");
    repeat (5) drive(4'b1000, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd250 || state !== 2'd1) begin n_fail++; $display("FAIL rej_fill: got %0d want 250", credit); end
    drive(4'b0100, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd250) begin
      n_fail++; $display("FAIL rej_overflow: got rej %b credit %0d want 1/250", coin_reject, credit);
    end
    drive(4'b0001, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b0 || credit !== 8'd255) begin
      n_fail++; $display("FAIL rej_edge255: got rej %b credit %0d want 0/255", coin_reject, credit);
    end
    drive(4'b0001, 0, 0, 0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd255) begin
      n_fail++; $display("FAIL rej_over255: got rej %b credit %0d want 1/255", coin_reject, credit);
    end
    drive(4'b0000, 0, 1, 0);
    queue_refund(255);
    expect_payout("refund255");
  endtask

  task automatic test_same_cycle();
    drive(4'b0100, 0, 0, 0);
    drive(4'b0010, 0, 0, 0);
    drive(4'b0001, 1, 0, 0);
    n_tests++;
    if (state !== 2'd2 || credit !== 8'd10) begin
      n_fail++; $display("FAIL same_buy_coin: got state %0d credit %0d want 2/10", state, credit);
    end
    drive(4'b0000, 0, 0, 1);
    queue_refund(10);
    expect_payout("buy_coin");
    drive(4'b0100, 0, 0, 0);
    drive(4'b0000, 1, 1, 0);
    n_tests++;
    if (state !== 2'd3 || credit !== 8'd20) begin
      n_fail++; $display("FAIL both_poor: got state %0d credit %0d want 3/20", state, credit);
    end
    queue_refund(20);
    expect_payout("both_poor");
    drive(4'b1000, 0, 0, 0);
    drive(4'b0000, 1, 1, 0);
    n_tests++;
    if (state !== 2'd2 || credit !== 8'd25) begin
      n_fail++; $display("FAIL both_rich: got state %0d credit %0d want 2/25", state, credit);
    end
    drive(4'b0000, 0, 0, 1);
    queue_refund(25);
    expect_payout("both_rich");
  endtask

  task automatic test_reset_mid_change();
    int guard = 0;
    drive(4'b0100, 0, 0, 0);
    drive(4'b0000, 0, 1, 0);
    while (!(credit === 8'd15 && money_out_contral === 1'b1) && guard < 40) begin step(); guard++; end
    n_tests++;
    if (guard >= 40) begin n_fail++; $display("FAIL rstmid_reach: got credit %0d want 15 with pulse", credit); end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({state, credit, drink_contral, money_out_contral, coin_reject, busy} !== 14'd0) begin
      n_fail++; $display("FAIL rstmid_async: got state %0d credit %0d money %b want 0", state, credit, money_out_contral);
    end
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (state !== 2'd0 || credit !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_release: got state %0d credit %0d want 0/0", state, credit);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    drive(4'b0010, 0, 0, 0);
    n_tests++;
    if (state !== 2'd1 || credit !== 8'd10) begin n_fail++; $display("FAIL tmo_coin: got %0d/%0d want 1/10", state, credit); end
`ifdef VEND_TIMEOUT_EN
    while (state === 2'd1 && n < 100) begin step(); n++; end
    n_tests++;
    if (n != TMO || state !== 2'd3) begin n_fail++; $display("FAIL tmo_fire: got %0d cycles want %0d", n, TMO); end
`else
    repeat (40) begin step(); n++; end
    n_tests++;
    if (state !== 2'd1 || credit !== 8'd10) begin
      n_fail++; $display("FAIL tmo_none: got state %0d after %0d cycles want 1", state, n);
    end
    drive(4'b0000, 0, 1, 0);
`endif
    queue_refund(10);
    expect_payout("timeout");
  endtask

  task automatic test_random();
    int model;
    int v;
    int ncoins;
    int a;
    int rem;
    logic [3:0] c;
    logic acc;
    for (int it = 0; it < 25; it++) begin
      model = 0;
      ncoins = $urandom_range(1, 5);
      for (int k = 0; k < ncoins; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          c = 4'($urandom_range(3, 15));
          if ($countones(c) < 2) c = 4'b1111;
        end else begin
          c = 4'(1 << $urandom_range(0, 3));
        end
        v = coin_value(c);
        acc = (v > 0) && (model + v <= 255);
        if (acc) model += v;
        drive(c, 0, 0, 0);
        n_tests++;
        if (credit !== 8'(model) || coin_reject !== !acc || state !== ((model > 0) ? 2'd1 : 2'd0)) begin
          n_fail++; $display("FAIL rnd_coin: got credit %0d rej %b state %0d want %0d/%b", credit, coin_reject, state, model, !acc);
        end
      end
      a = $urandom_range(0, 2);
      if (model == 0) begin
        drive(4'b0000, a != 1, a != 0, 0);
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL rnd_idle_ignore: got state %0d want 0", state); end
      end else if (a != 1 && model >= PRICE) begin
        drive(4'b0000, 1, a == 2, 0);
        n_tests++;
        if (state !== 2'd2 || credit !== 8'(model - PRICE)) begin
          n_fail++; $display("FAIL rnd_buy: got state %0d credit %0d want 2/%0d", state, credit, model - PRICE);
        end
        repeat ($urandom_range(0, 6)) step();
        drive(4'b0000, 0, 0, 1);
        rem = model - PRICE;
        if (rem == 0) begin
          n_tests++;
          if (state !== 2'd0 || drink_contral !== 1'b0) begin
            n_fail++; $display("FAIL rnd_exact: got state %0d want 0", state);
          end
        end else begin
          queue_refund(rem);
          expect_payout("rnd_buy");
        end
      end else begin
        if (a == 0) begin
          drive(4'b0000, 1, 0, 0);
          n_tests++;
          if (state !== 2'd1 || credit !== 8'(model)) begin
            n_fail++; $display("FAIL rnd_poor_buy: got state %0d credit %0d want 1/%0d", state, credit, model);
          end
        end
        drive(4'b0000, a == 2, 1, 0);
        queue_refund(model);
        expect_payout("rnd_cancel");
      end
    end
  endtask

  initial begin
    test_reset();
    test_vend_change();
    test_buy_short_cancel();
    test_reject();
    test_same_cycle();
    test_reset_mid_change();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Clocked controller that sequences the vending datapath: coin credit accumulation, purchase decision, drink dispense handshake and change payout. It replaces flag-driven state stepping with one registered FSM. It takes debounced coin/button/finish pulses from the front-end filters and drives the drink and coin-return actuators.

Parameters:
PRICE, 25, drink price in credit units; must be a multiple of CHANGE_UNIT.
CHANGE_UNIT, 5, value paid out per money_out_contral pulse.
PULSE_CYC, 4, cycles money_out_contral stays high, and then low, per payout pulse (>=1).
TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with VEND_TIMEOUT_EN).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
coin_in  input  4  one-cycle coin pulses; bit0=5, bit1=10, bit2=20, bit3=50.
buy  input  1  debounced one-cycle purchase request.
cancel  input  1  debounced one-cycle refund request.
drink_fin  input  1  debounced dispenser-done pulse.
drink_contral  output  1  dispense actuator enable.
money_out_contral  output  1  coin-return actuator pulse.
credit  output  8  current credit, registered.
coin_reject  output  1  one-cycle pulse: coin not credited.
busy  output  1  high in VEND or CHANGE.
state  output  2  IDLE=0, CREDIT=1, VEND=2, CHANGE=3.

Behaviour:
- Reset (rst=0, async): state=IDLE, credit=0, all outputs 0, pulse and timeout counters cleared. Applies mid-dispense or mid-payout; any credit is lost.
- Coin handling (IDLE/CREDIT only): exactly one coin_in bit set -> credit += value at the next edge (1-cycle latency), state=CREDIT. Zero bits -> nothing.
- Coin rejection: more than one bit set, or a sum exceeding 255 -> credit unchanged and coin_reject=1 for one cycle.
- Coins in VEND/CHANGE: coin_reject pulse, credit unchanged.
- CREDIT, buy, credit>=PRICE (value before any same-cycle coin): next state VEND, credit <= credit - PRICE + same-cycle coin value, drink_contral=1 from that edge.
- CREDIT, buy, credit<PRICE: ignored.
- buy and cancel in the same cycle: buy wins if affordable, else cancel.
- CREDIT, cancel: next state CHANGE; full credit is refunded. A same-cycle coin is credited first, then refunded.
- buy or cancel in IDLE: ignored.
- VEND: drink_contral held at 1 until drink_fin is sampled high. Next edge: drink_contral=0, then state=CHANGE if credit>0, else IDLE. buy/cancel ignored.
- CHANGE: repeat until credit==0.
  - money_out_contral high for PULSE_CYC cycles; on the last high cycle, credit -= CHANGE_UNIT.
  - money_out_contral low for PULSE_CYC cycles.
  - After the low phase with credit==0 -> IDLE.
  - Entry with credit==0 is impossible by construction.
- busy = (state==VEND)|(state==CHANGE), registered with the state.
- Credit invariant: credit is always a multiple of CHANGE_UNIT, because coin values and PRICE are multiples of it.

Optional Feature:
VEND_TIMEOUT_EN defined:
- In CREDIT, a counter increments each cycle with no coin, buy or cancel activity, and clears on any activity.
- On reaching TIMEOUT_CYC it acts as cancel: next state CHANGE, full refund.
- The counter is held at 0 outside CREDIT.
Undefined: no counter is built; CREDIT waits indefinitely.

Test Plan:
1. Coin 20, then 10, then buy; drink_fin 5 cycles later -> credit 20, 30, then 5. drink_contral high until drink_fin, one change pulse of 4 high / 4 low, then IDLE with credit 0.
2. Coin 20, then buy -> buy ignored, credit stays 20. Cancel -> 4 payout pulses, credit 15, 10, 5, 0, then IDLE.
3. coin_in=4'b0011, then a coin during VEND, then a coin pushing credit to 270 -> coin_reject pulse each time, credit unchanged.
4. Credit 30, buy and coin 5 in the same cycle -> VEND, credit 10 after dispense, 2 payout pulses.
5. Reset asserted mid-CHANGE with credit 15 -> outputs 0 and credit 0 immediately, with no clock edge needed. After release, state IDLE.
6. VEND_TIMEOUT_EN, TIMEOUT_CYC=16: coin 10, then no activity -> CHANGE entered 16 cycles later, 2 pulses. Without the macro -> stays in CREDIT.
